pl_fetch_seq_ctrl: RTL and testbench

Program-counter sequencer and hazard controller for the 5-stage RNS pipeline front end. It drives the instruction-memory address and request, and it advances, holds or redirects the PC. It detects load-use hazards between the ID-stage load and the IF-stage operands. It generates the stall, bubble and flush controls that gate the IF/ID pipeline register and invalidate wrong-path instructions after a taken branch.

---
 rtl/pl_fetch_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_pl_fetch_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pl_fetch_seq_ctrl.sv
// ============================================================================
// pl_fetch_seq_ctrl : PC sequencer and load-use / branch hazard control
// Rev 1.0
// ============================================================================
`default_nettype none

module pl_fetch_seq_ctrl #(
  parameter int                      PROG_CTR_WID = 10,
  parameter logic [PROG_CTR_WID-1:0] RESET_VECTOR = '0,
  parameter int                      FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    halt_req,
  input  logic                    imem_rdy,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] branch_target_EX,
  input  logic                    load_true_ID,
  input  logic [2:0]              ld_dest_ID,
  input  logic [2:0]              op1_addr_IF,
  input  logic [2:0]              op2_addr_IF,
  input  logic                    uses_ops_IF,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic                    imem_req,
  output logic                    stall_IF,
  output logic                    bubble_ID,
  output logic                    flush,
  output logic                    halted,
  output logic [2:0]              fsm_state,
  output logic [15:0]             fetch_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    STALL_LD = 3'd2,
    WAIT_MEM = 3'd3,
    FLUSH    = 3'd4,
    HALT     = 3'd5
  } state_t;

  localparam logic [PROG_CTR_WID-1:0] PC_ONE     = 1;
  localparam logic [1:0]              FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [1:0] flush_cnt;
  logic       hazard;

  assign hazard = load_true_ID & uses_ops_IF &
                  ((ld_dest_ID == op1_addr_IF) | (ld_dest_ID == op2_addr_IF));

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prog_ctr    <= RESET_VECTOR;
      imem_req    <= 1'b0;
      stall_IF    <= 1'b0;
      bubble_ID   <= 1'b0;
      flush       <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 16'd0;
      flush_cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            imem_req <= 1'b1;
          end
        end

        RUN, STALL_LD, WAIT_MEM: begin
          if (branch_taken_EX) begin
            prog_ctr  <= branch_target_EX;
            imem_req  <= 1'b1;
            flush     <= 1'b1;
            stall_IF  <= 1'b0;
            bubble_ID <= 1'b0;
            flush_cnt <= FLUSH_LOAD;
            state     <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
          end else if (halt_req) begin
            imem_req  <= 1'b0;
            halted    <= 1'b1;
            stall_IF  <= 1'b0;
            bubble_ID <= 1'b0;
            flush     <= 1'b0;
            state     <= HALT;
          end else if (state == RUN && hazard) begin
            // One bubble per load-use: STALL_LD never re-checks the hazard.
            stall_IF  <= 1'b1;
            bubble_ID <= 1'b1;
            flush     <= 1'b0;
            state     <= STALL_LD;
          end else if (!imem_rdy) begin
            stall_IF  <= 1'b1;
            bubble_ID <= 1'b0;
            flush     <= 1'b0;
            state     <= WAIT_MEM;
          end else begin
            prog_ctr  <= prog_ctr + PC_ONE;
            if (fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
            stall_IF  <= 1'b0;
            bubble_ID <= 1'b0;
            flush     <= 1'b0;
            state     <= RUN;
          end
        end

        FLUSH: begin
          imem_req <= 1'b1;
          if (flush_cnt == 2'd0) begin
            flush <= 1'b0;
            state <= RUN;
          end else begin
            flush     <= 1'b1;
            flush_cnt <= flush_cnt - 2'd1;
          end
        end

        HALT: begin
          if (start && !halt_req) begin
            halted   <= 1'b0;
            imem_req <= 1'b1;
            state    <= RUN;
          end
        end

        default: begin
          state     <= IDLE;
          imem_req  <= 1'b0;
          stall_IF  <= 1'b0;
          bubble_ID <= 1'b0;
          flush     <= 1'b0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pl_fetch_seq_ctrl.sv
// ============================================================================
// tb_pl_fetch_seq_ctrl : directed scoreboard bench for pl_fetch_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pl_fetch_seq_ctrl;

  localparam int PW = 10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STALL = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          halt_req;
  logic          imem_rdy;
  logic          branch_taken_EX;
  logic [PW-1:0] branch_target_EX;
  logic          load_true_ID;
  logic [2:0]    ld_dest_ID;
  logic [2:0]    op1_addr_IF;
  logic [2:0]    op2_addr_IF;
  logic          uses_ops_IF;
  logic [PW-1:0] prog_ctr;
  logic          imem_req;
  logic          stall_IF;
  logic          bubble_ID;
  logic          flush;
  logic          halted;
  logic [2:0]    fsm_state;
  logic [15:0]   fetch_count;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic          req;
    logic          stall;
    logic          bubble;
    logic          flush;
    logic          halted;
    logic [2:0]    st;
    logic [15:0]   fc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  pl_fetch_seq_ctrl #(
    .PROG_CTR_WID(PW),
    .RESET_VECTOR('0),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_rdy(imem_rdy), .branch_taken_EX(branch_taken_EX),
    .branch_target_EX(branch_target_EX), .load_true_ID(load_true_ID),
    .ld_dest_ID(ld_dest_ID), .op1_addr_IF(op1_addr_IF),
    .op2_addr_IF(op2_addr_IF), .uses_ops_IF(uses_ops_IF),
    .prog_ctr(prog_ctr), .imem_req(imem_req), .stall_IF(stall_IF),
    .bubble_ID(bubble_ID), .flush(flush), .halted(halted),
    .fsm_state(fsm_state), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Push the expected post-edge outputs, clock once, then pop and compare.
  task automatic step(input logic [PW-1:0] pc, input logic req, input logic stall,
                      input logic bubble, input logic fl, input logic hl,
                      input logic [2:0] st, input logic [15:0] fc);
    exp_t e;
    e = '{pc: pc, req: req, stall: stall, bubble: bubble, flush: fl,
          halted: hl, st: st, fc: fc};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("prog_ctr",    16'(prog_ctr),  16'(e.pc));
      chk("imem_req",    16'(imem_req),  16'(e.req));
      chk("stall_IF",    16'(stall_IF),  16'(e.stall));
      chk("bubble_ID",   16'(bubble_ID), 16'(e.bubble));
      chk("flush",       16'(flush),     16'(e.flush));
      chk("halted",      16'(halted),    16'(e.halted));
      chk("fsm_state",   16'(fsm_state), 16'(e.st));
      chk("fetch_count", fetch_count,    e.fc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; imem_rdy = 1'b1;
    branch_taken_EX = 1'b0; branch_target_EX = '0;
    load_true_ID = 1'b0; ld_dest_ID = 3'd0; op1_addr_IF = 3'd0;
    op2_addr_IF = 3'd0; uses_ops_IF = 1'b0;

    // Reset and start, free-run fetch
    step(10'h000, 0, 0, 0, 0, 0, S_IDLE, 16'd0);
    step(10'h000, 0, 0, 0, 0, 0, S_IDLE, 16'd0);
    rst = 1'b0;
    step(10'h000, 0, 0, 0, 0, 0, S_IDLE, 16'd0);
    start = 1'b1;
    step(10'h000, 1, 0, 0, 0, 0, S_RUN, 16'd0);
    start = 1'b0;
    step(10'h001, 1, 0, 0, 0, 0, S_RUN, 16'd1);
    step(10'h002, 1, 0, 0, 0, 0, S_RUN, 16'd2);
    step(10'h003, 1, 0, 0, 0, 0, S_RUN, 16'd3);

    // Redirect to 0x3FE; a second branch during FLUSH must be ignored
    branch_taken_EX = 1'b1; branch_target_EX = 10'h3FE;
    step(10'h3FE, 1, 0, 0, 1, 0, S_FLUSH, 16'd3);
    branch_target_EX = 10'h055;
    step(10'h3FE, 1, 0, 0, 1, 0, S_FLUSH, 16'd3);
    branch_taken_EX = 1'b0;
    step(10'h3FE, 1, 0, 0, 0, 0, S_RUN, 16'd3);
    step(10'h3FF, 1, 0, 0, 0, 0, S_RUN, 16'd4);
    step(10'h000, 1, 0, 0, 0, 0, S_RUN, 16'd5);
    step(10'h001, 1, 0, 0, 0, 0, S_RUN, 16'd6);
    step(10'h002, 1, 0, 0, 0, 0, S_RUN, 16'd7);
    step(10'h003, 1, 0, 0, 0, 0, S_RUN, 16'd8);
    step(10'h004, 1, 0, 0, 0, 0, S_RUN, 16'd9);
    step(10'h005, 1, 0, 0, 0, 0, S_RUN, 16'd10);

    // Load-use on op2 at PC=5, held through STALL_LD: exactly one bubble
    load_true_ID = 1'b1; ld_dest_ID = 3'd3; op2_addr_IF = 3'd3; uses_ops_IF = 1'b1;
    step(10'h005, 1, 1, 1, 0, 0, S_STALL, 16'd10);
    step(10'h006, 1, 0, 0, 0, 0, S_RUN, 16'd11);
    // Register match but operands unused: no hazard
    op2_addr_IF = 3'd0; op1_addr_IF = 3'd3; uses_ops_IF = 1'b0;
    step(10'h007, 1, 0, 0, 0, 0, S_RUN, 16'd12);
    load_true_ID = 1'b0; op1_addr_IF = 3'd0;

    // Memory not ready for 3 cycles at PC=7; hazard ignored in WAIT_MEM
    imem_rdy = 1'b0;
    step(10'h007, 1, 1, 0, 0, 0, S_WAIT, 16'd12);
    load_true_ID = 1'b1; ld_dest_ID = 3'd3; op1_addr_IF = 3'd3; uses_ops_IF = 1'b1;
    step(10'h007, 1, 1, 0, 0, 0, S_WAIT, 16'd12);
    step(10'h007, 1, 1, 0, 0, 0, S_WAIT, 16'd12);
    imem_rdy = 1'b1;
    step(10'h008, 1, 0, 0, 0, 0, S_RUN, 16'd13);
    load_true_ID = 1'b0; op1_addr_IF = 3'd0; uses_ops_IF = 1'b0;
    step(10'h009, 1, 0, 0, 0, 0, S_RUN, 16'd14);

    // Halt at PC=9; start together with halt_req keeps HALT
    halt_req = 1'b1;
    step(10'h009, 0, 0, 0, 0, 1, S_HALT, 16'd14);
    start = 1'b1;
    step(10'h009, 0, 0, 0, 0, 1, S_HALT, 16'd14);
    halt_req = 1'b0; start = 1'b0;
    step(10'h009, 0, 0, 0, 0, 1, S_HALT, 16'd14);
    step(10'h009, 0, 0, 0, 0, 1, S_HALT, 16'd14);
    start = 1'b1;
    step(10'h009, 1, 0, 0, 0, 0, S_RUN, 16'd14);
    start = 1'b0;
    step(10'h00A, 1, 0, 0, 0, 0, S_RUN, 16'd15);

    // Branch beats hazard and halt; halt deferred until FLUSH ends
    branch_taken_EX = 1'b1; branch_target_EX = 10'h120;
    load_true_ID = 1'b1; ld_dest_ID = 3'd2; op1_addr_IF = 3'd2; uses_ops_IF = 1'b1;
    halt_req = 1'b1;
    step(10'h120, 1, 0, 0, 1, 0, S_FLUSH, 16'd15);
    branch_taken_EX = 1'b0;
    step(10'h120, 1, 0, 0, 1, 0, S_FLUSH, 16'd15);
    step(10'h120, 1, 0, 0, 0, 0, S_RUN, 16'd15);
    step(10'h120, 0, 0, 0, 0, 1, S_HALT, 16'd15);
    halt_req = 1'b0; load_true_ID = 1'b0; uses_ops_IF = 1'b0;
    ld_dest_ID = 3'd0; op1_addr_IF = 3'd0;
    start = 1'b1;
    step(10'h120, 1, 0, 0, 0, 0, S_RUN, 16'd15);
    start = 1'b0;

    // Reset in the middle of FLUSH
    branch_taken_EX = 1'b1; branch_target_EX = 10'h200;
    step(10'h200, 1, 0, 0, 1, 0, S_FLUSH, 16'd15);
    branch_taken_EX = 1'b0; rst = 1'b1;
    step(10'h000, 0, 0, 0, 0, 0, S_IDLE, 16'd0);
    rst = 1'b0;
    step(10'h000, 0, 0, 0, 0, 0, S_IDLE, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
